// File: rtl/tone_decoder.sv
// Tone decoder: classifies a looped-back square wave as high, low or unknown tone.
// Optional input glitch filter enabled with `define TONE_DEC_GLITCH_FILTER_EN.
module tone_decoder #(
   parameter int HI_MIN    = 61440,
   parameter int HI_MAX    = 69632,
   parameter int LO_MIN    = 245760,
   parameter int LO_MAX    = 278528,
   parameter int TIMEOUT   = 524288,
   parameter int MATCH_CNT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tone_in,
   output logic [1:0]  tone_code,
   output logic        tone_valid,
   output logic [19:0] period,
   output logic [4:1]  led
);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } state_t;

   localparam int SW = $clog2(MATCH_CNT + 1);

   localparam logic [1:0]    C_LO   = 2'b01;
   localparam logic [1:0]    C_HI   = 2'b10;
   localparam logic [1:0]    C_UNK  = 2'b11;
   localparam logic [20:0]   HI_LB  = 21'(HI_MIN);
   localparam logic [20:0]   HI_UB  = 21'(HI_MAX);
   localparam logic [20:0]   LO_LB  = 21'(LO_MIN);
   localparam logic [20:0]   LO_UB  = 21'(LO_MAX);
   localparam logic [19:0]   TO_M1  = 20'(TIMEOUT - 1);
   localparam logic [19:0]   CNT_MX = '1;
   localparam logic [SW-1:0] MC     = SW'(MATCH_CNT);

   state_t        state;
   logic          s1;
   logic          s2;
   logic          lvl;
   logic          lvl_q;
   logic          rise;
   logic [19:0]   cnt;
   logic [20:0]   p_full;
   logic [1:0]    cls;
   logic [1:0]    cand;
   logic [SW-1:0] streak;
   logic [SW-1:0] nstreak;

`ifdef TONE_DEC_GLITCH_FILTER_EN
   logic h1;
   logic h2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h1 <= 1'b0;
         h2 <= 1'b0;
      end else begin
         h1 <= s2;
         h2 <= h1;
      end
   end

   // level only moves once three consecutive samples agree
   assign lvl = (s2 == h1 && h1 == h2) ? s2 : lvl_q;
`else
   assign lvl = s2;
`endif

   assign rise = lvl & ~lvl_q;

   always_comb begin
      p_full  = {1'b0, cnt} + 21'd1;
      cls     = C_UNK;
      nstreak = SW'(1);
      if (p_full >= HI_LB && p_full <= HI_UB) begin
         cls = C_HI;
      end else if (p_full >= LO_LB && p_full <= LO_UB) begin
         cls = C_LO;
      end
      if (cls == cand) begin
         nstreak = (streak >= MC) ? MC : streak + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         s1         <= 1'b0;
         s2         <= 1'b0;
         lvl_q      <= 1'b0;
         cnt        <= '0;
         streak     <= '0;
         cand       <= 2'b00;
         tone_code  <= 2'b00;
         tone_valid <= 1'b0;
         period     <= '0;
      end else begin
         s1    <= tone_in;
         s2    <= s1;
         lvl_q <= lvl;
         if (rise) begin
            cnt <= '0;
         end else if (cnt != CNT_MX) begin
            cnt <= cnt + 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= MEASURE;
               end
            end
            MEASURE, LOCKED: begin
               if (rise) begin
                  period <= p_full[20] ? CNT_MX : p_full[19:0];
                  cand   <= cls;
                  streak <= nstreak;
                  if (nstreak == MC) begin
                     tone_code  <= cls;
                     tone_valid <= (cls != C_UNK);
                     state      <= LOCKED;
                  end
               end else if (cnt == TO_M1) begin
                  state      <= IDLE;
                  tone_code  <= 2'b00;
                  tone_valid <= 1'b0;
                  streak     <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign led[1] = ~(tone_code == C_HI);
   assign led[2] = ~(tone_code == C_LO);
   assign led[3] = ~(tone_code == C_UNK);
   assign led[4] = ~tone_valid;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with scaled-down period windows.
// Latency constant follows TONE_DEC_GLITCH_FILTER_EN.
module tb_tone_decoder;

   localparam int HMIN = 60;
   localparam int HMAX = 68;
   localparam int LMIN = 240;
   localparam int LMAX = 272;
   localparam int TO   = 512;
   localparam int MC   = 3;
`ifdef TONE_DEC_GLITCH_FILTER_EN
   localparam int LAT  = 5;
`else
   localparam int LAT  = 3;
`endif

   logic        clk;
   logic        rst_n;
   logic        tone_in;
   logic [1:0]  tone_code;
   logic        tone_valid;
   logic [19:0] period;
   logic [4:1]  led;

   int checks = 0;
   int errors = 0;

   tone_decoder #(
      .HI_MIN(HMIN),
      .HI_MAX(HMAX),
      .LO_MIN(LMIN),
      .LO_MAX(LMAX),
      .TIMEOUT(TO),
      .MATCH_CNT(MC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tone_in(tone_in),
      .tone_code(tone_code),
      .tone_valid(tone_valid),
      .period(period),
      .led(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tone(input int p);
      tone_in = 1'b1;
      repeat (p / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
   endtask

   // one period whose rising edge completes a decision
   task automatic tone_chk(input string tag, input int p,
                           input logic [1:0] b, input logic [1:0] a);
      tone_in = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      chk({tag, "_pre"}, 32'(tone_code), 32'(b));
      @(negedge clk);
      chk({tag, "_post"}, 32'(tone_code), 32'(a));
      repeat (p / 2 - LAT) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      tone_in = 1'b0;
      repeat (5) begin
         @(negedge clk);
         tone_in = ~tone_in;
      end
      @(negedge clk);
      chk("rst_code", 32'(tone_code), 32'd0);
      chk("rst_valid", 32'(tone_valid), 32'd0);
      chk("rst_period", 32'(period), 32'd0);
      chk("rst_led", 32'(led), 32'hF);
      tone_in = 1'b0;
      rst_n   = 1'b1;
      repeat (20) @(negedge clk);

      repeat (3) tone(64);
      tone_chk("hi", 64, 2'b00, 2'b10);
      chk("hi_valid", 32'(tone_valid), 32'd1);
      chk("hi_period", 32'(period), 32'd64);
      chk("hi_led", 32'(led), 32'h6);

      repeat (3) tone(256);
      tone_chk("lo", 256, 2'b10, 2'b01);
      chk("lo_valid", 32'(tone_valid), 32'd1);
      chk("lo_period", 32'(period), 32'd256);
      chk("lo_led", 32'(led), 32'h5);

      repeat (LAT + TO - 1 - 256) @(negedge clk);
      chk("to_pre", 32'(tone_code), 32'd1);
      @(negedge clk);
      chk("to_code", 32'(tone_code), 32'd0);
      chk("to_valid", 32'(tone_valid), 32'd0);
      chk("to_period", 32'(period), 32'd256);
      chk("to_led", 32'(led), 32'hF);

      repeat (3) tone(100);
      tone_chk("unk", 100, 2'b00, 2'b11);
      chk("unk_valid", 32'(tone_valid), 32'd0);
      chk("unk_period", 32'(period), 32'd100);
      chk("unk_led", 32'(led), 32'hB);

      for (int i = 0; i < 4; i++) begin
         tone(64);
         chk("alt_hi", 32'(tone_code), 32'd3);
         tone(256);
         chk("alt_lo", 32'(tone_code), 32'd3);
      end
      chk("alt_period", 32'(period), 32'd64);

      rst_n   = 1'b0;
      tone_in = 1'b0;
      @(negedge clk);
      chk("mrst_code", 32'(tone_code), 32'd0);
      chk("mrst_valid", 32'(tone_valid), 32'd0);
      chk("mrst_period", 32'(period), 32'd0);
      chk("mrst_led", 32'(led), 32'hF);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      tone(64);
      chk("first_edge", 32'(period), 32'd0);
      tone(64);
      chk("second_edge", 32'(period), 32'd64);
      chk("second_code", 32'(tone_code), 32'd0);

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         tone_in = 1'b1;
         repeat (i % 2 + 1) @(negedge clk);
         tone_in = 1'b0;
         repeat (150 - (i % 2 + 1)) @(negedge clk);
      end
`ifdef TONE_DEC_GLITCH_FILTER_EN
      chk("glitch_code", 32'(tone_code), 32'd0);
      chk("glitch_period", 32'(period), 32'd0);
      chk("glitch_led", 32'(led), 32'hF);
`else
      chk("glitch_code", 32'(tone_code), 32'd3);
      chk("glitch_period", 32'(period), 32'd150);
      chk("glitch_led", 32'(led), 32'hB);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
